unisim_sram_b_param: RTL

UNISIM_SRAM_B_PARAM -- requirements
Module: unisim_sram_b_param

---
 rtl/unisim_sram_b_pkg.sv | 21 ++
 rtl/unisim_sram_bram.sv | 40 ++++
 rtl/unisim_sram_scrub.sv | 49 ++++
 rtl/unisim_sram_b_param.sv | 109 ++++++++++
 4 files changed

// File: rtl/unisim_sram_b_pkg.sv
// rtl/unisim_sram_b_pkg.sv - shared scrub state encoding and bank geometry helpers
// Purpose: types and functions common to every unisim_sram_b variant.
//   scrub_state_e : two-state scrub/ready FSM encoding
//   calc_nl       : number of data lanes, ceil(dbits / bank_dbits)
//   calc_nv       : number of vertical bank rows, 2^(abits - bank_abits)
package unisim_sram_b_pkg;

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_READY = 1'b1
  } scrub_state_e;

  function automatic int calc_nl(input int dbits, input int bank_dbits);
    return (dbits + bank_dbits - 1) / bank_dbits;
  endfunction

  function automatic int calc_nv(input int abits, input int bank_abits);
    return 1 << (abits - bank_abits);
  endfunction

endpackage

// File: rtl/unisim_sram_bram.sv
// rtl/unisim_sram_bram.sv - simple dual-port block RAM bank (BRAM_<2^AW>x<DW>)
// Purpose: one bank of the array; bit-masked write port, registered read port.
// Ports:
//   clk   in  clock
//   rstn  in  synchronous active-low reset of the output register only
//   we    in  write strobe
//   waddr in  write address
//   wdata in  write data
//   wmask in  per-bit write mask, 1 = write
//   re    in  read strobe
//   raddr in  read address
//   q     out registered read data, held while re is low
module unisim_sram_bram #(
  parameter int AW = 14,
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] wmask,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
  end

  // Read-first: a same-address write is not visible here; the top forwards it.
  always_ff @(posedge clk) begin
    if (!rstn)   q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/unisim_sram_scrub.sv
// rtl/unisim_sram_scrub.sv - post-reset zero-fill sequencer for the bank array
// Purpose: walks every bank address once after reset, then declares ready.
// Ports:
//   clk        in  clock
//   rstn       in  synchronous active-low reset
//   rdy        out high once every bank address has been cleared
//   scrub_en   out write-all-banks strobe during the scrub pass
//   scrub_addr out bank address being cleared this cycle
module unisim_sram_scrub
  import unisim_sram_b_pkg::*;
#(
  parameter int BANK_ABITS = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  rdy,
  output logic                  scrub_en,
  output logic [BANK_ABITS-1:0] scrub_addr
);

  scrub_state_e          state, state_next;
  logic [BANK_ABITS-1:0] count, count_next;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_SCRUB;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    scrub_en   = 1'b0;
    if (state == ST_SCRUB) begin
      scrub_en   = 1'b1;
      count_next = count + 1'b1;
      // Last address is cleared this cycle; ready follows on the next edge.
      if (count == '1) state_next = ST_READY;
    end
  end

  assign rdy        = (state == ST_READY);
  assign scrub_addr = count;

endmodule

// File: rtl/unisim_sram_b_param.sv
// rtl/unisim_sram_b_param.sv - banked SRAM with zero-scrub, 1-cycle read, write-first forwarding
// Purpose: builds an ABITS x DBITS memory from NV rows by NL lanes of banks.
// Ports:
//   CLK  in  clock          RSTN in  synchronous active-low reset
//   CE0  in  write enable   A0   in  write address   D0 in write data
//   WE0  in  write strobe   WEM0 in  per-bit write mask
//   CE1  in  read enable    A1   in  read address    Q1 out read data
//   RDY  out high once the scrub pass is complete
module unisim_sram_b_param
  import unisim_sram_b_pkg::*;
#(
  parameter int ABITS      = 17,
  parameter int DBITS      = 8,
  parameter int BANK_ABITS = 14,
  parameter int BANK_DBITS = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CE0,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  input  logic             WE0,
  input  logic [DBITS-1:0] WEM0,
  input  logic             CE1,
  input  logic [ABITS-1:0] A1,
  output logic [DBITS-1:0] Q1,
  output logic             RDY
);

  localparam int NL = calc_nl(DBITS, BANK_DBITS);
  localparam int NV = calc_nv(ABITS, BANK_ABITS);
  localparam int RW = ABITS - BANK_ABITS;

  logic                  scrub_en;
  logic [BANK_ABITS-1:0] scrub_addr;
  logic                  wr_en, rd_en;
  logic [RW-1:0]         wr_row, rd_row, rd_row_q;
  logic [BANK_ABITS-1:0] waddr;
  logic [DBITS-1:0]      byp_mask_q, byp_data_q;
  logic [DBITS-1:0]      mem_word;
  wire  [NV-1:0][DBITS-1:0] bank_q;

  unisim_sram_scrub #(.BANK_ABITS(BANK_ABITS)) u_scrub (
    .clk        (CLK),
    .rstn       (RSTN),
    .rdy        (RDY),
    .scrub_en   (scrub_en),
    .scrub_addr (scrub_addr)
  );

  assign wr_en  = CE0 & WE0 & RDY;
  assign rd_en  = CE1 & RDY;
  assign wr_row = A0[ABITS-1:BANK_ABITS];
  assign rd_row = A1[ABITS-1:BANK_ABITS];
  assign waddr  = scrub_en ? scrub_addr : A0[BANK_ABITS-1:0];

  for (genvar v = 0; v < NV; v++) begin : g_row
    for (genvar h = 0; h < NL; h++) begin : g_lane
      // Last lane is narrowed when DBITS is not a multiple of BANK_DBITS.
      localparam int LW = (DBITS - h*BANK_DBITS < BANK_DBITS) ? (DBITS - h*BANK_DBITS) : BANK_DBITS;
      logic [LW-1:0] lane_wdata, lane_wmask;
      logic          lane_we, lane_re;

      assign lane_wdata = scrub_en ? '0 : D0[h*BANK_DBITS +: LW];
      assign lane_wmask = scrub_en ? '1 : WEM0[h*BANK_DBITS +: LW];
      assign lane_we    = scrub_en | (wr_en & (wr_row == RW'(v)));
      assign lane_re    = rd_en & (rd_row == RW'(v));

      unisim_sram_bram #(.AW(BANK_ABITS), .DW(LW)) u_bank (
        .clk   (CLK),
        .rstn  (RSTN),
        .we    (lane_we),
        .waddr (waddr),
        .wdata (lane_wdata),
        .wmask (lane_wmask),
        .re    (lane_re),
        .raddr (A1[BANK_ABITS-1:0]),
        .q     (bank_q[v][h*BANK_DBITS +: LW])
      );
    end
  end

  // Row select and forwarding state move only with a read, so Q1 holds between reads.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rd_row_q   <= '0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else if (rd_en) begin
      rd_row_q <= rd_row;
      if (wr_en && (A0 == A1)) begin
        byp_mask_q <= WEM0;
        byp_data_q <= D0;
      end else begin
        byp_mask_q <= '0;
        byp_data_q <= '0;
      end
    end
  end

  assign mem_word = bank_q[rd_row_q];
  assign Q1       = (mem_word & ~byp_mask_q) | (byp_data_q & byp_mask_q);

  // Scrub owns the write port; a user write landing on top of it would be lost.
  always_ff @(posedge CLK) begin
    if (RSTN) assert (!(scrub_en && wr_en));
  end

endmodule
